// File: rtl/cordic_quadrant_wrap.sv
// Purpose : Four-quadrant front/back end around a cordic core. It folds the operands
//           into the core's convergence range, runs the start/done handshake with the
//           core, and undoes the fold on the result.
// Latency : cord_start is high in the first cycle after the request is accepted, if
//           cord_ready is high. out_valid rises 2 cycles after cord_done rises, when
//           cord_done is a single-cycle pulse.
// Backpressure: one operation is in flight at a time. in_ready is high only in IDLE.
//           Results are held in RESULT until out_ready is seen.
// Ports   : clk, reset_n (async, active low)
//           upstream   in_valid/in_ready, in_mode, in_angle, in_x, in_y
//           downstream out_valid/out_ready, out_mode, out_angle, out_x, out_y
//           core side  cord_start/cord_ready/cord_done, cord_mode, cord_in_*, cord_out_*
module cordic_quadrant_wrap #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_angle,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_angle,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             cord_start,
    output logic             cord_mode,
    output logic [WIDTH-1:0] cord_in_angle,
    output logic [WIDTH-1:0] cord_in_x,
    output logic [WIDTH-1:0] cord_in_y,
    input  logic             cord_ready,
    input  logic             cord_done,
    input  logic [WIDTH-1:0] cord_out_angle,
    input  logic [WIDTH-1:0] cord_out_x,
    input  logic [WIDTH-1:0] cord_out_y
);

    // Binary angle constants: 2^WIDTH corresponds to 2*pi.
    localparam logic [WIDTH-1:0] HALF_TURN = {1'b1, {(WIDTH-1){1'b0}}};   // pi, also the most negative value
    localparam logic [WIDTH-1:0] POS_QTR   = {2'b01, {(WIDTH-2){1'b0}}};  // +pi/2
    localparam logic [WIDTH-1:0] NEG_QTR   = {2'b11, {(WIDTH-2){1'b0}}};  // -pi/2
    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             alive_q;      // low during reset so that in_ready reads 0 while reset_n is asserted
    logic             started_q;    // cord_start has been raised for this op, so keep it up regardless of cord_ready
    logic             mode_q;
    logic             flip_q;
    logic [WIDTH-1:0] cin_angle_q, cin_x_q, cin_y_q;
    logic [WIDTH-1:0] res_angle_q, res_x_q, res_y_q;

    logic             accept;
    logic             capture;
    logic             red_flip;
    logic [WIDTH-1:0] red_angle, red_x, red_y;
    logic [WIDTH-1:0] cor_angle, cor_x, cor_y;

    // Negation that maps the one unrepresentable case (-2^(W-1)) to the largest positive value.
    function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
        if (v == HALF_TURN) begin
            return MAX_POS;
        end
        return -v;
    endfunction

    // Operand reduction.
    // Rotation: an angle outside [-pi/2, +pi/2] is moved by pi. Adding 2^(W-1) modulo 2^W
    // only inverts the MSB. -pi therefore lands on 0.
    // Vectoring: a vector with x < 0 is mirrored through the origin into quadrants I/IV.
    always_comb begin
        red_angle = in_angle;
        red_x     = in_x;
        red_y     = in_y;
        red_flip  = 1'b0;
        if (!in_mode) begin
            if ($signed(in_angle) > $signed(POS_QTR) || $signed(in_angle) < $signed(NEG_QTR)) begin
                red_angle = in_angle ^ HALF_TURN;
                red_flip  = 1'b1;
            end
        end else begin
            red_angle = '0;
            if (in_x[WIDTH-1]) begin
                red_x    = sat_neg(in_x);
                red_y    = sat_neg(in_y);
                red_flip = 1'b1;
            end
        end
    end

    // Post-correction.
    // Rotating by (a - pi) and then negating the vector gives the same result as
    // rotating by a. A mirrored vector has its angle offset by pi.
    always_comb begin
        cor_angle = cord_out_angle;
        cor_x     = cord_out_x;
        cor_y     = cord_out_y;
        if (flip_q) begin
            if (!mode_q) begin
                cor_x = sat_neg(cord_out_x);
                cor_y = sat_neg(cord_out_y);
            end else begin
                cor_angle = cord_out_angle ^ HALF_TURN;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)          state_d = ISSUE;
            ISSUE:   if (capture)         state_d = DRAIN;
            // Leave DRAIN only after done has dropped. A long done level therefore
            // cannot be seen as a second completion.
            DRAIN:   if (!cord_done)      state_d = RESULT;
            RESULT:  if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready   = alive_q && (state_q == IDLE);
        cord_start = (state_q == ISSUE) && (started_q || cord_ready);
        out_valid  = (state_q == RESULT);
    end

    assign accept  = in_valid && in_ready;
    assign capture = cord_start && cord_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            alive_q   <= 1'b1;
            started_q <= cord_start && !cord_done;
        end
    end

    // Operand registers. They are loaded on acceptance and then held until the next request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= 1'b0;
            flip_q      <= 1'b0;
            cin_angle_q <= '0;
            cin_x_q     <= '0;
            cin_y_q     <= '0;
        end else if (accept) begin
            mode_q      <= in_mode;
            flip_q      <= red_flip;
            cin_angle_q <= red_angle;
            cin_x_q     <= red_x;
            cin_y_q     <= red_y;
        end
    end

    // Result registers. They are loaded once, on the first done seen while start is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_angle_q <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
        end else if (capture) begin
            res_angle_q <= cor_angle;
            res_x_q     <= cor_x;
            res_y_q     <= cor_y;
        end
    end

    assign cord_mode     = mode_q;
    assign cord_in_angle = cin_angle_q;
    assign cord_in_x     = cin_x_q;
    assign cord_in_y     = cin_y_q;
    assign out_mode      = mode_q;
    assign out_angle     = res_angle_q;
    assign out_x         = res_x_q;
    assign out_y         = res_y_q;

endmodule

// File: doc/cordic_quadrant_wrap.md
Name: cordic_quadrant_wrap

Overview:
- Front/back-end stage wrapped around the cordic core; owns the cordic start/done handshake.
- Extends the core's convergence range to all four quadrants.
  - Rotation: maps any angle into [-pi/2, +pi/2] before issue and corrects the result after.
  - Vectoring: maps x<0 into quadrants I/IV and corrects the angle after.
- Upstream and downstream use valid/ready handshakes; one operation in flight at a time.

Parameters:
- WIDTH, 32: data and angle width. Angles are signed binary angles; 2^WIDTH = 2*pi, so +pi/2 = 2^(WIDTH-2).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  wrapper can accept a request
- in_mode  input  1  0 = rotation, 1 = vectoring
- in_angle  input  WIDTH  signed rotation angle (ignored in vectoring)
- in_x, in_y  input  WIDTH each  signed coordinates
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_mode  output  1  mode of the result
- out_angle, out_x, out_y  output  WIDTH each  corrected results; not gain-compensated, so the cordic gain (~1.6468) remains
- cord_start  output  1  to cordic start
- cord_mode  output  1  to cordic mode
- cord_in_angle, cord_in_x, cord_in_y  output  WIDTH each  reduced operands
- cord_ready  input  1  cordic idle
- cord_done  input  1  cordic result valid, level
- cord_out_angle, cord_out_x, cord_out_y  input  WIDTH each  cordic results

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State = IDLE; all outputs and registers = 0.
  - in_ready = 0 during reset; in_ready = 1 on the first cycle after release.
- FSM: IDLE -> ISSUE -> DRAIN -> RESULT -> IDLE.
- IDLE:
  - in_ready = 1 only in IDLE.
  - On in_valid, register mode and the reduced operands plus a flip flag, then go to ISSUE.
- Rotation reduction:
  - If in_angle > 2^(W-2) or in_angle < -2^(W-2): cord_in_angle = in_angle - 2^(W-1) (mod 2^W wrap) and flip = 1.
  - Otherwise pass through with flip = 0.
  - Exactly +/-2^(W-2) is not flipped; -2^(W-1) maps to 0 with flip = 1.
  - x and y pass unchanged.
- Vectoring reduction:
  - If in_x < 0: cord_in_x = sat_neg(in_x), cord_in_y = sat_neg(in_y), flip = 1.
  - sat_neg(-2^(W-1)) = 2^(W-1)-1.
  - cord_in_angle = 0.
- ISSUE:
  - cord_start = 1 only once cord_ready = 1; it stays high until the first cycle cord_done = 1.
  - On that cycle, capture corrected results into the out_* registers, drop cord_start next cycle, and go to DRAIN.
- DRAIN: wait for cord_done = 0, then go to RESULT. A done level left over from the prior op is never re-captured.
- RESULT:
  - out_valid = 1; out_* held stable.
  - On out_valid & out_ready, out_valid drops next cycle and the FSM returns to IDLE.
  - Earliest next in_ready is the cycle after acceptance.
- Post-correction:
  - Rotation with flip: out_x = sat_neg(cord_out_x), out_y = sat_neg(cord_out_y), out_angle = cord_out_angle.
  - Vectoring with flip: out_angle = cord_out_angle + 2^(W-1) (mod 2^W wrap); x and y pass through.
  - flip = 0: all results pass unchanged.
- Latency: in handshake -> cord_start = 1 cycle (if cord_ready) -> cordic latency -> out_valid 2 cycles after cord_done rises.
- reset_n asserted mid-operation drops cord_start and out_valid immediately. The cordic core shares reset_n, so no drain is required.
- The cord_* operand outputs hold stable from ISSUE until the next request.

Test Plan:
- Rotation, in_x = 2^30, in_y = 0, in_angle = 0 -> cord_in_angle = 0, flip = 0; out_x ~ 2^30 * 1.6468, out_y ~ 0 (within 16 LSB).
- Rotation, in_angle = 0xC0000000 (-pi/2, boundary) -> not flipped, cord_in_angle = 0xC0000000; in_angle = 0x80000000 (-pi) -> cord_in_angle = 0, out_x ~ -2^30 * 1.6468.
- Rotation, in_angle = 0x60000000 (135 deg) -> cord_in_angle = 0xE0000000; out_x and out_y are the negated cordic outputs; verify against a cos/sin reference to 16 LSB.
- Vectoring, in_x = -1000000, in_y = 0 -> cord_in_x = 1000000; out_angle ~ 0x80000000 (pi), out_x ~ 1000000 * 1.6468.
- Vectoring, in_x = 0x80000000 -> cord_in_x = 0x7FFFFFFF (saturated); no X or overflow.
- Handshake: hold out_ready = 0 for 20 cycles -> out_* stable and in_ready = 0; cord_done held high 3 extra cycles -> exactly one capture. Assert reset_n mid-ISSUE -> cord_start = 0 and out_valid = 0 asynchronously; in_ready = 1 after release.
